usb_tx_bit_encoder: RTL and testbench

//  Serial back end of the USB full-speed transmitter. Takes packet bytes from the TX packet
//  FSM and paces them with bit_strobe, a 1-cycle pulse from the TX bit-period counter rollover.

---
 rtl/usb_tx_bit_encoder.sv | 198 +++++++++++++++++++
 tb/tb_usb_tx_bit_encoder.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_bit_encoder.sv
// USB full-speed transmit back end: serializes bytes LSB first, inserts stuff bits,
// NRZI-encodes the stream and appends EOP, all paced by bit_strobe.
module usb_tx_bit_encoder #(
  parameter int STUFF_LIMIT  = 6,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       bit_strobe,
  input  logic       pkt_start,
  input  logic [7:0] byte_data,
  input  logic       byte_last,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       dp_out,
  output logic       dm_out,
  output logic       tx_busy,
  output logic       stuff_active,
  output logic       tx_done,
  output logic       tx_error
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    SHIFT,
    STUFF,
    EOP_SE0,
    EOP_J
  } state_t;

  localparam logic [2:0] ONES_LIMIT = 3'(STUFF_LIMIT);
  localparam logic [1:0] SE0_LEN    = 2'(EOP_SE0_BITS);

  state_t     state;
  logic [7:0] buf_data;
  logic       buf_last;
  logic       buf_full;
  logic [6:0] shift_reg;
  logic [2:0] bit_idx;
  logic       cur_last;
  logic [2:0] ones_cnt;
  logic [1:0] se0_cnt;
  logic       nrzi_j;

  logic accept;
  logic send_valid;
  logic send_bit;
  logic load_buf;
  logic go_eop;
  logic underrun;
  logic do_stuff;
  logic next_level;
  logic buf_full_next;
  logic eop_next;

  assign accept = byte_valid & byte_ready;

  // Decide what the current bit_strobe does; the stuff check wins over advancing.
  always_comb begin
    send_valid = 1'b0;
    send_bit   = 1'b0;
    load_buf   = 1'b0;
    go_eop     = 1'b0;
    underrun   = 1'b0;
    do_stuff   = 1'b0;
    if (bit_strobe) begin
      case (state)
        WAIT_DATA: begin
          if (buf_full) begin
            load_buf   = 1'b1;
            send_valid = 1'b1;
            send_bit   = buf_data[0];
          end
        end
        SHIFT, STUFF: begin
          if (state == SHIFT && ones_cnt == ONES_LIMIT) begin
            do_stuff = 1'b1;
          end else if (bit_idx != 3'd7) begin
            send_valid = 1'b1;
            send_bit   = shift_reg[0];
          end else if (cur_last) begin
            go_eop = 1'b1;
          end else if (buf_full) begin
            load_buf   = 1'b1;
            send_valid = 1'b1;
            send_bit   = buf_data[0];
          end else begin
            underrun = 1'b1;
            go_eop   = 1'b1;
          end
        end
        default: ;
      endcase
    end
    next_level = nrzi_j;
    if (do_stuff || (send_valid && !send_bit)) begin
      next_level = ~nrzi_j;
    end
    buf_full_next = accept | (buf_full & ~load_buf);
    eop_next      = go_eop | (state == EOP_SE0) | ((state == EOP_J) & ~bit_strobe);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      dp_out       <= 1'b1;
      dm_out       <= 1'b0;
      byte_ready   <= 1'b1;
      tx_busy      <= 1'b0;
      stuff_active <= 1'b0;
      tx_done      <= 1'b0;
      tx_error     <= 1'b0;
      buf_data     <= 8'd0;
      buf_last     <= 1'b0;
      buf_full     <= 1'b0;
      shift_reg    <= 7'd0;
      bit_idx      <= 3'd0;
      cur_last     <= 1'b0;
      ones_cnt     <= 3'd0;
      se0_cnt      <= 2'd0;
      nrzi_j       <= 1'b1;
    end else begin
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
      buf_full   <= buf_full_next;
      byte_ready <= ~buf_full_next & ~eop_next;
      if (accept) begin
        buf_data <= byte_data;
        buf_last <= byte_last;
      end

      case (state)
        IDLE: begin
          if (pkt_start) begin
            tx_busy <= 1'b1;
            state   <= WAIT_DATA;
          end
        end
        WAIT_DATA, SHIFT, STUFF: begin
          if (do_stuff) begin
            state        <= STUFF;
            stuff_active <= 1'b1;
            ones_cnt     <= 3'd0;
          end else if (send_valid) begin
            state        <= SHIFT;
            stuff_active <= 1'b0;
            if (load_buf) begin
              shift_reg <= buf_data[7:1];
              bit_idx   <= 3'd0;
              cur_last  <= buf_last;
            end else begin
              shift_reg <= shift_reg >> 1;
              bit_idx   <= bit_idx + 3'd1;
            end
            ones_cnt <= send_bit ? ones_cnt + 3'd1 : 3'd0;
          end else if (go_eop) begin
            state        <= EOP_SE0;
            stuff_active <= 1'b0;
            se0_cnt      <= 2'd1;
            tx_error     <= underrun;
          end
          // Stuffed and data bits share the NRZI path; EOP overrides it with SE0.
          if (do_stuff || send_valid) begin
            nrzi_j <= next_level;
            dp_out <= next_level;
            dm_out <= ~next_level;
          end else if (go_eop) begin
            dp_out <= 1'b0;
            dm_out <= 1'b0;
          end
        end
        EOP_SE0: begin
          if (bit_strobe) begin
            if (se0_cnt == SE0_LEN) begin
              state  <= EOP_J;
              dp_out <= 1'b1;
              dm_out <= 1'b0;
            end else begin
              se0_cnt <= se0_cnt + 2'd1;
            end
          end
        end
        EOP_J: begin
          if (bit_strobe) begin
            tx_done  <= 1'b1;
            tx_busy  <= 1'b0;
            nrzi_j   <= 1'b1;
            ones_cnt <= 3'd0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_bit_encoder.sv
// Bench for usb_tx_bit_encoder: hand-derived packet table, reset/corner sequences and
// random packets checked against a bit-stream model (stuff, NRZI, EOP).
module tb_usb_tx_bit_encoder;

  localparam int STUFF_LIMIT  = 6;
  localparam int EOP_SE0_BITS = 2;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic       bit_strobe = 1'b0;
  logic       pkt_start = 1'b0;
  logic [7:0] byte_data = 8'd0;
  logic       byte_last = 1'b0;
  logic       byte_valid = 1'b0;
  logic       byte_ready;
  logic       dp_out;
  logic       dm_out;
  logic       tx_busy;
  logic       stuff_active;
  logic       tx_done;
  logic       tx_error;

  usb_tx_bit_encoder #(
    .STUFF_LIMIT (STUFF_LIMIT),
    .EOP_SE0_BITS(EOP_SE0_BITS)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .bit_strobe  (bit_strobe),
    .pkt_start   (pkt_start),
    .byte_data   (byte_data),
    .byte_last   (byte_last),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .dp_out      (dp_out),
    .dm_out      (dm_out),
    .tx_busy     (tx_busy),
    .stuff_active(stuff_active),
    .tx_done     (tx_done),
    .tx_error    (tx_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         nbytes;
    logic [7:0] b0;
    logic [7:0] b1;
    bit         underrun;
    string      line;
    int         stuff_idx;
    int         gate;
    int         mid_start;
    bit         coincide;
    bit         ready_chk;
  } vec_t;

  vec_t       vecs[$];
  int         vectors = 0;
  int         miscompares = 0;
  // One record per bit period: {dp, dm, stuff_active, tx_error, tx_done, tx_busy}
  logic [5:0] exp_q[$];
  logic [5:0] cap_q[$];
  bit         cap_ready[$];
  logic [7:0] feed_data[$];
  bit         feed_last[$];
  int         feed_gate = 0;
  int         strobes_done = 0;
  bit         first_acc = 1'b0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, act, req);
    end
  endtask

  function automatic logic [5:0] sym(input logic dp, input logic dm, input logic stf,
                                     input logic err, input logic done, input logic busy);
    return {dp, dm, stf, err, done, busy};
  endfunction

  function automatic void add_vec(input string name, input int nbytes, input logic [7:0] b0,
                                  input logic [7:0] b1, input bit underrun, input string line,
                                  input int stuff_idx, input int gate, input int mid_start,
                                  input bit coincide, input bit ready_chk);
    vec_t v;
    v.name = name; v.nbytes = nbytes; v.b0 = b0; v.b1 = b1; v.underrun = underrun;
    v.line = line; v.stuff_idx = stuff_idx; v.gate = gate; v.mid_start = mid_start;
    v.coincide = coincide; v.ready_chk = ready_chk;
    vecs.push_back(v);
  endfunction

  function automatic void add_tail(input bit underrun);
    for (int k = 0; k < EOP_SE0_BITS; k++) exp_q.push_back(sym(0, 0, 0, underrun && k == 0, 0, 1));
    exp_q.push_back(sym(1, 0, 0, 0, 0, 1));
    exp_q.push_back(sym(1, 0, 0, 0, 1, 0));
  endfunction

  function automatic void expect_from_line(input string line, input int stuff_idx, input bit underrun);
    logic j;
    exp_q.delete();
    for (int i = 0; i < line.len(); i++) begin
      j = (line.getc(i) == "J");
      exp_q.push_back(sym(j, !j, i == stuff_idx, 0, 0, 1));
    end
    add_tail(underrun);
  endfunction

  // Reference: flatten bytes LSB first, stuff a 0 after each run of STUFF_LIMIT ones, then NRZI.
  function automatic void model_expected(input bit underrun);
    bit         stream[$];
    logic [7:0] v;
    int         ones = 0;
    bit         lvl = 1'b1;
    exp_q.delete();
    foreach (feed_data[i]) begin
      v = feed_data[i];
      for (int b = 0; b < 8; b++) stream.push_back(v[b]);
    end
    foreach (stream[i]) begin
      if (!stream[i]) lvl = !lvl;
      exp_q.push_back(sym(lvl, !lvl, 0, 0, 0, 1));
      ones = stream[i] ? ones + 1 : 0;
      if (ones == STUFF_LIMIT) begin
        lvl = !lvl;
        exp_q.push_back(sym(lvl, !lvl, 1, 0, 0, 1));
        ones = 0;
      end
    end
    add_tail(underrun);
  endfunction

  task automatic feed();
    int t;
    @(negedge clk);
    for (int i = 0; i < feed_data.size(); i++) begin
      t = 0;
      if (i == 1) begin
        while (strobes_done < feed_gate && t < 400) begin
          @(negedge clk);
          t++;
        end
      end
      byte_valid = 1'b1;
      byte_data  = feed_data[i];
      byte_last  = feed_last[i];
      t = 0;
      while (!byte_ready && t < 400) begin
        @(negedge clk);
        t++;
      end
      if (!byte_ready) begin
        check_output("feed_ready_timeout", 32'(byte_ready), 32'd1);
        byte_valid = 1'b0;
        return;
      end
      @(posedge clk);
      if (i == 0) first_acc = 1'b1;
      @(negedge clk);
      byte_valid = 1'b0;
      byte_last  = 1'b0;
    end
  endtask

  task automatic drive(input int mid_start_at, input bit coincide, input int abort_at);
    int         t = 0;
    logic [5:0] prev;
    while (!first_acc && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!first_acc) return;
    @(negedge clk);
    pkt_start  = 1'b1;
    bit_strobe = coincide;
    @(negedge clk);
    pkt_start  = 1'b0;
    bit_strobe = 1'b0;
    prev = sym(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 80; i++) begin
      repeat (2) @(negedge clk);
      check_output("line_hold", 32'({dp_out, dm_out}), 32'(prev[5:4]));
      bit_strobe = 1'b1;
      if (i == mid_start_at) pkt_start = 1'b1;
      @(negedge clk);
      bit_strobe = 1'b0;
      pkt_start  = 1'b0;
      prev = sym(dp_out, dm_out, stuff_active, tx_error, tx_done, tx_busy);
      cap_q.push_back(prev);
      cap_ready.push_back(byte_ready);
      strobes_done++;
      if (i == abort_at) return;
      if (tx_done) begin
        @(negedge clk);
        check_output("done_pulse_width", 32'(tx_done), 32'd0);
        return;
      end
    end
    check_output("tx_done_timeout", 32'(tx_done), 32'd1);
  endtask

  task automatic apply_stimulus(input int mid_start_at, input bit coincide, input int abort_at);
    first_acc    = 1'b0;
    strobes_done = 0;
    cap_q.delete();
    cap_ready.delete();
    fork
      feed();
      drive(mid_start_at, coincide, abort_at);
    join
  endtask

  task automatic compare_packet(input string name);
    check_output({name, "_len"}, 32'(cap_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      check_output($sformatf("%s[%0d]", name, i), 32'(cap_q[i]), 32'(exp_q[i]));
  endtask

  task automatic load_feed(input logic [7:0] b0, input logic [7:0] b1, input int nbytes, input bit underrun);
    feed_data.delete();
    feed_last.delete();
    feed_data.push_back(b0);
    feed_last.push_back(nbytes == 1 ? !underrun : 1'b0);
    if (nbytes == 2) begin
      feed_data.push_back(b1);
      feed_last.push_back(!underrun);
    end
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Expected lines are hand-derived NRZI sequences starting from J.
    add_vec("single_80",      1, 8'h80, 8'h00, 0, "KJKJKJKK",          -1, 0, -1, 0, 0);
    add_vec("ff_then_00",     2, 8'hFF, 8'h00, 0, "JJJJJJKKKJKJKJKJK",  6, 0, -1, 0, 0);
    add_vec("underrun_01",    1, 8'h01, 8'h00, 1, "JKJKJKJK",          -1, 0, -1, 0, 0);
    add_vec("late_second",    2, 8'h55, 8'h80, 0, "JKKJJKKJKJKJKJKK",  -1, 4, -1, 0, 1);
    add_vec("fc_stuff_end",   1, 8'hFC, 8'h00, 0, "KJJJJJJJK",          8, 0, -1, 0, 0);
    add_vec("f0_0f_carry",    2, 8'hF0, 8'h0F, 0, "KJKJJJJJJJKKKJKJK", 10, 0, -1, 0, 0);
    add_vec("mid_pkt_start",  1, 8'h80, 8'h00, 0, "KJKJKJKK",          -1, 0,  3, 0, 0);
    add_vec("start_w_strobe", 1, 8'h80, 8'h00, 0, "KJKJKJKK",          -1, 0, -1, 1, 0);

    #1 n_rst = 1'b0;
    #1;
    check_output("rst_dp", 32'(dp_out), 32'd1);
    check_output("rst_dm", 32'(dm_out), 32'd0);
    check_output("rst_ready", 32'(byte_ready), 32'd1);
    check_output("rst_busy", 32'(tx_busy), 32'd0);
    check_output("rst_stuff", 32'(stuff_active), 32'd0);
    check_output("rst_done", 32'(tx_done), 32'd0);
    check_output("rst_error", 32'(tx_error), 32'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[v]) begin
      load_feed(vecs[v].b0, vecs[v].b1, vecs[v].nbytes, vecs[v].underrun);
      feed_gate = vecs[v].gate;
      expect_from_line(vecs[v].line, vecs[v].stuff_idx, vecs[v].underrun);
      apply_stimulus(vecs[v].mid_start, vecs[v].coincide, -1);
      compare_packet(vecs[v].name);
      if (vecs[v].ready_chk && cap_ready.size() > 8) begin
        for (int i = 3; i <= 8; i++)
          check_output($sformatf("%s_ready[%0d]", vecs[v].name, i), 32'(cap_ready[i]),
                       (i >= 4 && i <= 7) ? 32'd0 : 32'd1);
      end
      repeat (3) @(negedge clk);
    end

    // Reset during bit4 with a second byte already buffered.
    feed_gate = 0;
    load_feed(8'h80, 8'h01, 2, 0);
    apply_stimulus(-1, 0, 4);
    check_output("pre_rst_dp", 32'(dp_out), 32'd0);
    check_output("pre_rst_ready", 32'(byte_ready), 32'd0);
    check_output("pre_rst_busy", 32'(tx_busy), 32'd1);
    n_rst = 1'b0;
    #1;
    check_output("mid_rst_dp", 32'(dp_out), 32'd1);
    check_output("mid_rst_dm", 32'(dm_out), 32'd0);
    check_output("mid_rst_ready", 32'(byte_ready), 32'd1);
    check_output("mid_rst_busy", 32'(tx_busy), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    load_feed(8'h80, 8'h00, 1, 0);
    expect_from_line("KJKJKJKK", -1, 0);
    apply_stimulus(-1, 0, -1);
    compare_packet("after_reset");
    repeat (3) @(negedge clk);

    for (int p = 0; p < 24; p++) begin
      int n;
      bit ur;
      n  = $urandom_range(1, 4);
      ur = ($urandom_range(0, 4) == 0);
      feed_data.delete();
      feed_last.delete();
      for (int i = 0; i < n; i++) begin
        feed_data.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
        feed_last.push_back((i == n - 1) && !ur);
      end
      feed_gate = 0;
      model_expected(ur);
      apply_stimulus(-1, 0, -1);
      compare_packet($sformatf("rand%0d", p));
      repeat (3) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
